// File: rtl/keypad_pkg.sv
// Shared constants, types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    // Internal 5-bit key result: {no_key, row[1:0], col[1:0]}
    localparam logic [4:0] NO_KEY = 5'b10000;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } key_state_t;

    // Lowest active (low) column of one row, or NO_KEY when nothing is pressed
    function automatic logic [4:0] row_hit(input logic [1:0] row, input logic [3:0] cols);
        logic [4:0] hit;
        hit = NO_KEY;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!cols[c]) hit = {1'b0, row, 2'(c)};
        end
        return hit;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce: counts identical consecutive frames and runs the press FSM.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] frame_res,
    input  logic       frame_done,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    key_state_t    state, state_next;
    logic [4:0]    prev, prev_next;
    logic [SW-1:0] stable, stable_next;
    logic [3:0]    code_next;
    logic          valid_next;
    logic          confirmed;

    // State, history and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RELEASED;
            prev      <= NO_KEY;
            stable    <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_next;
            prev      <= prev_next;
            stable    <= stable_next;
            key_code  <= code_next;
            key_valid <= valid_next;
        end
    end

    // Stability counting and press/release/rollover decisions, once per frame
    always_comb begin
        state_next  = state;
        prev_next   = prev;
        stable_next = stable;
        code_next   = key_code;
        valid_next  = 1'b0;
        confirmed   = 1'b0;
        if (frame_done) begin
            if (frame_res == prev)
                stable_next = (stable == STABLE_MAX) ? stable : stable + 1'b1;
            else
                stable_next = SW'(1);
            prev_next = frame_res;
            confirmed = (stable_next == STABLE_MAX);
            if (confirmed) begin
                case (state)
                    RELEASED: begin
                        if (!frame_res[4]) begin
                            state_next = PRESSED;
                            code_next  = frame_res[3:0];
                            valid_next = 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (frame_res[4]) begin
                            state_next = RELEASED;
                        end else if (frame_res[3:0] != key_code) begin
                            code_next  = frame_res[3:0];
                            valid_next = 1'b1;
                        end
                    end
                    default: state_next = RELEASED;
                endcase
            end
        end
    end

    assign key_held = (state == PRESSED);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner: column sync, row strobing, per-frame lowest-key capture.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] KEY_COL,
    output logic [3:0] KEY_ROW,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(SCAN_DIV - 1);

    logic [3:0]    col_meta, col_sync;
    logic [TW-1:0] tick;
    logic [1:0]    row;
    logic [4:0]    acc, merged;
    logic          sample, frame_done;

    // Two-flop synchronizer; idle columns are pulled high
    always_ff @(posedge CLK) begin
        if (RST) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= KEY_COL;
            col_sync <= col_meta;
        end
    end

    assign sample     = (tick == TICK_MAX);
    assign frame_done = sample && (row == 2'd3);

    // Row slot timer and row index
    always_ff @(posedge CLK) begin
        if (RST) begin
            tick <= '0;
            row  <= '0;
        end else if (sample) begin
            tick <= '0;
            row  <= row + 2'd1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    // First hit in scan order is the lowest index, so keep it once captured
    assign merged = acc[4] ? row_hit(row, col_sync) : acc;

    // Frame accumulator, cleared after the row-3 sample
    always_ff @(posedge CLK) begin
        if (RST)
            acc <= NO_KEY;
        else if (sample)
            acc <= (row == 2'd3) ? NO_KEY : merged;
    end

    assign KEY_ROW = ~(4'b0001 << row);

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (CLK),
        .rst        (RST),
        .frame_res  (merged),
        .frame_done (frame_done),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_held   (key_held)
    );

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Row-scanning reader for a 4×4 matrix keypad, the input-side counterpart of the time-multiplexed 7-segment digit driver. It strobes one row at a time at a divided scan rate and samples the columns. It then debounces the per-frame result and presents a single key code with a one-cycle press strobe. Game control logic (speed selection, start/reset of score) consumes `key_code`/`key_valid` in the `CLK` domain.

## Interface
- `SCAN_DIV`, 25000: `CLK` cycles per row slot; 1 kHz row rate at 25 MHz.
- `DEBOUNCE_SCANS`, 4: consecutive identical frames required to accept a press or release (≥1).
- `CLK`  input  1  system clock; all logic on rising edge.
- `RST`  input  1  synchronous, active-high reset.
- `KEY_COL`  input  4  column lines, active-low (pulled up), asynchronous to `CLK`.
- `KEY_ROW`  output  4  row strobes, active-low, exactly one row low at any time.
- `key_code`  output  4  accepted key index = row*4 + col; holds last value after release.
- `key_valid`  output  1  one-cycle pulse when a new press is accepted.
- `key_held`  output  1  high while the accepted key remains pressed.

## Operation
- `KEY_COL` passes through a 2-flop synchronizer; all sampling uses the synchronized value.
- Tick counter `tick` runs 0..SCAN_DIV-1 and wraps. Row index `row` (0..3) advances on wrap; 3 wraps to 0. `KEY_ROW = ~(4'b0001 << row)`.
- Sample point: the cycle where `tick == SCAN_DIV-1`. The synchronized columns are read for the current row.
- Frame accumulator: the lowest active column in a row yields candidate `row*4+col`. Across a frame, the lowest index wins; rows are scanned 0→3, so the first hit is kept. No hit gives NO_KEY.
- Frame end is the sample of row 3. The frame result is compared with the previous frame result.
  - Equal: increment `stable`, saturating at `DEBOUNCE_SCANS`.
  - Different: `stable` = 1.
- Debounce FSM (`stable` reaching `DEBOUNCE_SCANS` is "confirmed"):
  - RELEASED: a confirmed key goes to PRESSED. Load `key_code`, pulse `key_valid`, set `key_held`.
  - PRESSED, confirmed NO_KEY: go to RELEASED and clear `key_held`. `key_code` is unchanged.
  - PRESSED, confirmed different key: direct rollover. Load the new `key_code` and pulse `key_valid`.
  - PRESSED, same key confirmed: no action. Holding never repeats `key_valid`.
- Multiple simultaneous keys: the lowest index is reported. The rest are ignored.
- `RST` mid-scan: everything returns to reset values on the next edge, and scanning restarts at row 0.

## Timing
- Reset values:
  - `KEY_ROW` = 4'b1110.
  - `key_code` = 0, `key_valid` = 0, `key_held` = 0.
  - `tick` = 0, `row` = 0, `stable` = 0.
  - Previous frame = NO_KEY; FSM in RELEASED.
- Row slot = `SCAN_DIV` cycles. Frame = 4·`SCAN_DIV` cycles.
- Columns must settle within `SCAN_DIV`-3 cycles of a row change. This budget covers the 2-flop synchronizer plus margin.
- `key_valid`/`key_held` update on the edge after the frame-end sample cycle.
- Press latency from a stable press: at most (`DEBOUNCE_SCANS`+1) frames + 3 cycles. Release latency has the same bound.
- `key_valid` is never high for two consecutive cycles.

## Structure
- Shared package `keypad_pkg` holds:
  - `ROWS`/`COLS` = 4.
  - `NO_KEY` encoding (5-bit internal result, MSB set).
  - `key_state_t` enum {RELEASED, PRESSED}.
- One sub-module, `keypad_debounce`.
  - Inputs: frame result and a frame-done strobe.
  - Contents: `stable` counter and FSM.
  - Outputs: `key_code`, `key_valid`, `key_held`.
- The top level holds the synchronizer, tick/row counters and frame accumulator.

## Test plan
Benches use `SCAN_DIV`=8 and `DEBOUNCE_SCANS`=2, with a keypad model that drives `KEY_COL[c]` low when the row for key r*4+c is low.
- Reset, no key: `KEY_ROW` cycles 1110→1101→1011→0111 every 8 cycles. `key_valid` stays 0 and `key_code` = 0.
- Hold key 6 for 5 frames:
  - Exactly one `key_valid` pulse, with `key_code`=6 and `key_held`=1.
  - After release, `key_held` drops within 3 frames and `key_code` stays 6.
- Bounce key 9 (toggle every 3 cycles for 1 frame, then stable 4 frames): exactly one pulse, `key_code`=9.
- Press keys 13 and 2 together: `key_code`=2. Release 2 while holding 13: a second pulse with `key_code`=13.
- Assert `RST` while PRESSED mid-frame: next cycle all outputs are at reset values and `KEY_ROW`=1110. Still-held key 6 is re-accepted with one new pulse.
- Press key 15 for only 1 frame: no `key_valid`.
